data_mem_wb: RTL and testbench

- Parametrised successor of the CPU data-memory port: connects the CPU MEM stage to the shared memory bus.
- Adds a posted-write buffer (FIFO), so stores retire without waiting for bus_done.
- Adds byte enables and a hold input. Loads stay ordered behind buffered stores.
- Sits between the CPU pipeline and the bus arbiter/memory unit.

---
 rtl/data_mem_pkg.sv | 16 +
 rtl/wb_fifo.sv | 47 ++++
 rtl/data_mem_wb.sv | 139 +++++++++++++
 tb/tb_data_mem_wb.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types for the CPU data-memory port with posted-write buffer.
// Holds the bus FSM encoding and the write-buffer entry width helper.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    // One buffered store is packed as {addr, data, be}.
    function automatic int entry_w(input int aw, input int dw, input int bw);
        return aw + dw + bw;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO backing the posted-write buffer.
// Ports: clk, reset (sync, active-low), push/din, pop/dout (head), full, empty, count.
module wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [PW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[head];

    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + PW'(1);
            if (do_pop)  head <= head + PW'(1);
            count <= count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[tail] <= din;
    end

endmodule

// File: rtl/data_mem_wb.sv
// CPU MEM-stage port to the shared memory bus with a posted-write buffer.
// Ports: CPU side (addr,data,be,we,re,hold -> q,busy,wb_empty), bus side (bus_* ).
import data_mem_pkg::*;

module data_mem_wb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int WB_DEPTH = 4,
    parameter int BE_W     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic [BE_W-1:0]   be,
    input  logic              we,
    input  logic              re,
    input  logic              hold,
    output logic [DATA_W-1:0] q,
    output logic              busy,
    output logic              wb_empty,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data,
    output logic [BE_W-1:0]   bus_be,
    output logic              bus_we,
    output logic              bus_start,
    input  logic [DATA_W-1:0] bus_q,
    input  logic              bus_done,
    input  logic              bus_ready
);

    localparam int EW = entry_w(ADDR_W, DATA_W, BE_W);
    localparam int CW = $clog2(WB_DEPTH) + 1;

    state_t            state;
    state_t            state_n;
    logic [EW-1:0]     head;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              load_go;
    logic              rd_done;
    logic              latch_wr;
    logic              latch_rd;
    logic [DATA_W-1:0] qreg;

    // Full is the registered count, so a same-cycle pop never frees a slot.
    assign push    = we & ~hold & ~full;
    // A store in the same cycle takes precedence; the load is not launched.
    assign load_go = re & ~we & ~hold & bus_ready & empty & (state == IDLE);

    wb_fifo #(
        .WIDTH (EW),
        .DEPTH (WB_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   ({addr, data, be}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        rd_done  = 1'b0;
        latch_wr = 1'b0;
        latch_rd = 1'b0;
        unique case (state)
            IDLE: begin
                // Draining has priority so loads stay behind older stores.
                if (!empty && bus_ready) begin
                    state_n  = WR;
                    latch_wr = 1'b1;
                end else if (load_go) begin
                    state_n  = RD;
                    latch_rd = 1'b1;
                end
            end
            WR: begin
                if (bus_done) begin
                    state_n = IDLE;
                    pop     = 1'b1;
                end
            end
            RD: begin
                if (bus_done) begin
                    state_n = IDLE;
                    rd_done = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus_start <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_data  <= '0;
            bus_be    <= '0;
            qreg      <= '0;
        end else begin
            bus_start <= latch_wr | latch_rd;
            if (latch_wr) begin
                bus_addr <= head[EW-1 -: ADDR_W];
                bus_data <= head[BE_W +: DATA_W];
                bus_be   <= head[BE_W-1:0];
                bus_we   <= 1'b1;
            end
            if (latch_rd) begin
                bus_addr <= addr;
                bus_be   <= '1;
                bus_we   <= 1'b0;
            end
            if (rd_done) qreg <= bus_q;
        end
    end

    assign busy     = (we & full) | (~we & re & ~rd_done);
    assign q        = rd_done ? bus_q : qreg;
    assign wb_empty = (count == '0) & (state == IDLE);

endmodule

// File: tb/tb_data_mem_wb.sv
// Directed self-checking bench for data_mem_wb (32-bit and 64-bit instances).
// Bus side is modelled by a responder that logs every transaction start.
module tb_data_mem_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, data, q, bus_addr, bus_data, bus_q;
    logic [3:0]  be, bus_be;
    logic        we, re, hold, busy, wb_empty;
    logic        bus_we, bus_start, bus_done, bus_ready;

    logic [31:0] w_addr, w_addr_o;
    logic [63:0] w_data, w_q, w_bus_data, w_bus_q;
    logic [7:0]  w_be, w_bus_be;
    logic        w_we, w_re, w_busy, w_wb_empty;
    logic        w_bus_we, w_bus_start, w_done;

    always #5 clk = ~clk;

    data_mem_wb u_dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .data      (data),
        .be        (be),
        .we        (we),
        .re        (re),
        .hold      (hold),
        .q         (q),
        .busy      (busy),
        .wb_empty  (wb_empty),
        .bus_addr  (bus_addr),
        .bus_data  (bus_data),
        .bus_be    (bus_be),
        .bus_we    (bus_we),
        .bus_start (bus_start),
        .bus_q     (bus_q),
        .bus_done  (bus_done),
        .bus_ready (bus_ready)
    );

    data_mem_wb #(.DATA_W(64)) u_dut64 (
        .clk       (clk),
        .reset     (reset),
        .addr      (w_addr),
        .data      (w_data),
        .be        (w_be),
        .we        (w_we),
        .re        (w_re),
        .hold      (1'b0),
        .q         (w_q),
        .busy      (w_busy),
        .wb_empty  (w_wb_empty),
        .bus_addr  (w_addr_o),
        .bus_data  (w_bus_data),
        .bus_be    (w_bus_be),
        .bus_we    (w_bus_we),
        .bus_start (w_bus_start),
        .bus_q     (w_bus_q),
        .bus_done  (w_done),
        .bus_ready (1'b1)
    );

    typedef struct {
        bit          we;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
    } txn_t;

    txn_t log_q[$];
    int   lat     = 2;
    bit   auto_en = 1'b1;
    logic auto_done = 1'b0;
    logic man_done  = 1'b0;
    int   cnt = 0;
    bit   act = 1'b0;
    bit   overlap = 1'b0;

    assign bus_done = auto_done | man_done;

    // Bus responder: bus_done arrives lat cycles after the start cycle.
    always @(posedge clk) begin
        auto_done <= 1'b0;
        if (!auto_en || !reset) begin
            act <= 1'b0;
        end else if (bus_start) begin
            if (act) overlap <= 1'b1;
            log_q.push_back('{bus_we, bus_addr, bus_data, bus_be});
            if (lat <= 1) begin
                auto_done <= 1'b1;
                act       <= 1'b0;
            end else begin
                act <= 1'b1;
                cnt <= lat - 1;
            end
        end else if (act) begin
            if (cnt == 1) begin
                auto_done <= 1'b1;
                act       <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_start(input string nm);
        for (int i = 0; i < 40; i++) begin
            smp();
            if (bus_start === 1'b1) return;
            cyc();
        end
        timeout(nm);
    endtask

    task automatic wait_empty(input string nm);
        for (int i = 0; i < 60; i++) begin
            smp();
            if (wb_empty === 1'b1) return;
            cyc();
        end
        timeout(nm);
    endtask

    task automatic wait_not_busy(input string nm);
        for (int i = 0; i < 60; i++) begin
            smp();
            if (busy === 1'b0) return;
            cyc();
        end
        timeout(nm);
    endtask

    task automatic w_wait_start(input string nm);
        for (int i = 0; i < 40; i++) begin
            smp();
            if (w_bus_start === 1'b1) return;
            cyc();
        end
        timeout(nm);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b);
        we   = 1'b1;
        addr = a;
        data = d;
        be   = b;
        cyc();
        we = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
        logic [31:0] rq;
        logic [3:0]  eb;
        logic [31:0] eq;
    } vec_t;

    vec_t vecs[5];
    int   nbusy;

    initial begin
        vecs[0] = '{1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF, 32'h0, 4'hF, 32'h0};
        vecs[1] = '{1'b1, 32'h14, 32'h0123_4567, 4'h3, 32'h0, 4'h3, 32'h0};
        vecs[2] = '{1'b0, 32'h10, 32'h0, 4'h0, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D};
        vecs[3] = '{1'b1, 32'h1C, 32'hFFFF_0000, 4'h8, 32'h0, 4'h8, 32'h0};
        vecs[4] = '{1'b0, 32'h24, 32'h0, 4'h0, 32'h0BAD_BEEF, 4'hF, 32'h0BAD_BEEF};

        reset = 1'b0; we = 0; re = 0; hold = 0; bus_ready = 1'b1;
        addr = '0; data = '0; be = '0; bus_q = '0;
        w_addr = '0; w_data = '0; w_be = '0; w_we = 0; w_re = 0;
        w_bus_q = '0; w_done = 0;
        cyc();
        cyc();
        reset = 1'b1;
        smp();
        chk("rst_wb_empty", wb_empty, 1);
        chk("rst_busy", busy, 0);
        chk("rst_q", q, 0);
        chk("rst_bus_start", bus_start, 0);
        chk("rst_bus_addr", bus_addr, 0);
        cyc();

        // Reset in the middle of a write with three stores buffered.
        bus_ready = 1'b0;
        store(32'h1, 32'h11, 4'hF);
        store(32'h2, 32'h22, 4'hF);
        store(32'h3, 32'h33, 4'hF);
        auto_en   = 1'b0;
        bus_ready = 1'b1;
        wait_start("rstmid_start");
        cyc();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        smp();
        chk("rstmid_wb_empty", wb_empty, 1);
        chk("rstmid_bus_start", bus_start, 0);
        chk("rstmid_bus_we", bus_we, 0);
        chk("rstmid_bus_addr", bus_addr, 0);
        chk("rstmid_bus_be", bus_be, 0);
        cyc();
        man_done = 1'b1;
        cyc();
        man_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("late_done_start", bus_start, 0);
            chk("late_done_empty", wb_empty, 1);
            chk("late_done_q", q, 0);
            cyc();
        end
        auto_en = 1'b1;
        log_q.delete();

        // Single store: start two cycles after accept, done three after start.
        lat = 3;
        we = 1'b1; addr = 32'h100; data = 32'hDEAD_BEEF; be = 4'hF;
        smp();
        chk("st_busy_accept", busy, 0);
        cyc();
        we = 1'b0;
        smp();
        chk("st_start_early", bus_start, 0);
        chk("st_not_empty", wb_empty, 0);
        cyc();
        smp();
        chk("st_start", bus_start, 1);
        chk("st_bus_we", bus_we, 1);
        chk("st_bus_addr", bus_addr, 32'h100);
        chk("st_bus_data", bus_data, 32'hDEAD_BEEF);
        chk("st_bus_be", bus_be, 4'hF);
        cyc();
        smp();
        chk("st_start_pulse", bus_start, 0);
        chk("st_addr_stable", bus_addr, 32'h100);
        cyc();
        smp();
        chk("st_in_flight", wb_empty, 0);
        cyc();
        smp();
        chk("st_done", bus_done, 1);
        chk("st_wait_pop", wb_empty, 0);
        cyc();
        smp();
        chk("st_empty_after", wb_empty, 1);
        cyc();

        // Table of stores and loads.
        lat = 2;
        foreach (vecs[k]) begin
            log_q.delete();
            if (vecs[k].wr) begin
                we = 1'b1; addr = vecs[k].a; data = vecs[k].d; be = vecs[k].b;
                smp();
                chk($sformatf("v%0d_busy", k), busy, 0);
                cyc();
                we = 1'b0;
                wait_start($sformatf("v%0d_start", k));
                chk($sformatf("v%0d_we", k), bus_we, 1);
                chk($sformatf("v%0d_data", k), bus_data, vecs[k].d);
            end else begin
                re = 1'b1; addr = vecs[k].a; bus_q = vecs[k].rq;
                smp();
                chk($sformatf("v%0d_busy", k), busy, 1);
                cyc();
                wait_start($sformatf("v%0d_start", k));
                chk($sformatf("v%0d_we", k), bus_we, 0);
            end
            chk($sformatf("v%0d_addr", k), bus_addr, vecs[k].a);
            chk($sformatf("v%0d_be", k), bus_be, vecs[k].eb);
            cyc();
            if (!vecs[k].wr) begin
                wait_not_busy($sformatf("v%0d_done", k));
                chk($sformatf("v%0d_q", k), q, vecs[k].eq);
                cyc();
                re = 1'b0;
                bus_q = 32'h0;
                smp();
                chk($sformatf("v%0d_q_held", k), q, vecs[k].eq);
                cyc();
            end
            wait_empty($sformatf("v%0d_empty", k));
            cyc();
        end

        // Fill to full with the bus stalled, fifth store waits for a pop.
        log_q.delete();
        lat = 1;
        bus_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; addr = 32'h400 + 32'(i * 4);
            data = 32'hF000_0000 + 32'(i); be = 4'hF;
            smp();
            chk($sformatf("full_acc%0d_busy", i), busy, 0);
            cyc();
        end
        addr = 32'h410; data = 32'hF000_0004;
        bus_ready = 1'b1;
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            smp();
            if (busy !== 1'b1) break;
            nbusy++;
            cyc();
        end
        chk("full_busy_cycles", 64'(nbusy), 3);
        cyc();
        we = 1'b0;
        wait_empty("full_drain");
        chk("full_log_len", 64'(log_q.size()), 5);
        for (int i = 0; i < 5 && i < log_q.size(); i++) begin
            chk($sformatf("full_ord%0d_addr", i), log_q[i].a, 32'h400 + 32'(i * 4));
            chk($sformatf("full_ord%0d_data", i), log_q[i].d, 32'hF000_0000 + 32'(i));
        end
        cyc();

        // Load behind two stores.
        log_q.delete();
        lat = 2;
        store(32'h180, 32'hAAAA_0001, 4'hF);
        store(32'h184, 32'hAAAA_0002, 4'hF);
        re = 1'b1; addr = 32'h200; bus_q = 32'h1234_5678;
        wait_not_busy("lbs_done");
        chk("lbs_q", q, 32'h1234_5678);
        chk("lbs_bus_done", bus_done, 1);
        cyc();
        re = 1'b0;
        bus_q = 32'h0;
        smp();
        chk("lbs_q_held", q, 32'h1234_5678);
        chk("lbs_log_len", 64'(log_q.size()), 3);
        if (log_q.size() == 3) begin
            chk("lbs_w1", log_q[1].a, 32'h184);
            chk("lbs_rd_we", log_q[2].we, 0);
            chk("lbs_rd_addr", log_q[2].a, 32'h200);
        end
        cyc();

        // Hold blocks the load but not the drain.
        log_q.delete();
        store(32'h80, 32'h55, 4'h1);
        hold = 1'b1; re = 1'b1; addr = 32'h300; bus_q = 32'h77;
        for (int i = 0; i < 10; i++) begin
            smp();
            chk("hold_no_read", bus_start & ~bus_we, 0);
            chk("hold_busy", busy, 1);
            cyc();
        end
        smp();
        chk("hold_drained", wb_empty, 1);
        chk("hold_log_len", 64'(log_q.size()), 1);
        cyc();
        hold = 1'b0;
        smp();
        chk("hold_rel_start0", bus_start, 0);
        cyc();
        smp();
        chk("hold_rel_start", bus_start, 1);
        chk("hold_rel_we", bus_we, 0);
        chk("hold_rel_addr", bus_addr, 32'h300);
        cyc();
        wait_not_busy("hold_rd_done");
        chk("hold_q", q, 32'h77);
        cyc();
        re = 1'b0;
        chk("no_overlap", overlap, 0);

        // 64-bit instance byte enables.
        w_we = 1'b1; w_addr = 32'h40; w_be = 8'h0F;
        w_data = 64'h1122_3344_5566_7788;
        cyc();
        w_we = 1'b0;
        w_wait_start("w64_st_start");
        chk("w64_st_be", w_bus_be, 8'h0F);
        chk("w64_st_data", w_bus_data, 64'h1122_3344_5566_7788);
        w_done = 1'b1;
        cyc();
        w_done = 1'b0;
        smp();
        chk("w64_empty", w_wb_empty, 1);
        cyc();
        w_re = 1'b1; w_addr = 32'h48; w_bus_q = 64'hFEDC_BA98_7654_3210;
        cyc();
        w_wait_start("w64_rd_start");
        chk("w64_rd_be", w_bus_be, 8'hFF);
        chk("w64_rd_we", w_bus_we, 0);
        w_done = 1'b1;
        #1;
        chk("w64_rd_q", w_q, 64'hFEDC_BA98_7654_3210);
        chk("w64_rd_busy", w_busy, 0);
        cyc();
        w_done = 1'b0;
        w_re = 1'b0;
        w_bus_q = '0;
        smp();
        chk("w64_q_held", w_q, 64'hFEDC_BA98_7654_3210);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
